// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton conditioning path: key bit positions and default timing.
// The key-stroke encoder uses the same bit order.
package key_debounce_pkg;

  localparam int NUM_KEYS      = 5;
  localparam int DEBOUNCE_10MS = 250000;  // 10 ms at 25 MHz
  localparam int DEBOUNCE_CNT_W = 18;

  typedef enum logic [2:0] {
    KEY_PAUSE = 3'd0,
    KEY_RIGHT = 3'd1,
    KEY_LEFT  = 3'd2,
    KEY_DOWN  = 3'd3,
    KEY_UP    = 3'd4
  } key_idx_e;

  // Pin value of a released button.
  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One pushbutton channel: synchroniser chain, stability counter, debounced level and edge pulses.
module debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_10MS,
  parameter int CNT_W         = DEBOUNCE_CNT_W,
  parameter int SYNC_STAGES   = 2,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic clk_25M,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam logic             IDLE_PIN = idle_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   level_r;
  logic                   press_r;
  logic                   release_r;
  logic                   synced_s;

  // Polarity is normalised after the chain so the flops only ever see the raw pin.
  assign synced_s = sync_r[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Synchroniser chain into clk_25M.
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{IDLE_PIN}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], key_raw};
    end
  end

  // Stability filter: any sample agreeing with the current level restarts the count.
  always_ff @(posedge clk_25M or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      if (synced_s == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r     <= '0;
        level_r   <= synced_s;
        press_r   <= synced_s;
        release_r <= ~synced_s;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign key_level   = level_r;
  assign key_press   = press_r;
  assign key_release = release_r;

endmodule

// File: rtl/key_debounce.sv
// Debounces the board pushbuttons (up, down, left, right, pause) for the key-stroke encoder.
// Channels are independent; each output bit comes straight from its channel's flops.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS        = NUM_KEYS,
  parameter int STABLE_CYCLES = DEBOUNCE_10MS,
  parameter int CNT_W         = DEBOUNCE_CNT_W,
  parameter int SYNC_STAGES   = 2,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic              clk_25M,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W),
      .SYNC_STAGES   (SYNC_STAGES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_chan (
      .clk_25M     (clk_25M),
      .rst         (rst),
      .key_raw     (key_raw[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule
